// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage and its neighbours
// (controller, instruction register, accumulator immediates).
package instruction_fetch_pkg;

  localparam int PC_W    = 4;
  localparam int DEPTH   = 16;
  localparam int INSTR_W = 8;

  localparam logic [INSTR_W-1:0] NOP = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    VALID,
    HALT
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Bus between the fetch stage (slave) and the controller/loader side (master).
interface instruction_fetch_if;
  import instruction_fetch_pkg::*;

  logic               prog_we;
  logic [PC_W-1:0]    prog_addr;
  logic [INSTR_W-1:0] prog_data;
  logic               run;
  logic               LoadIR;
  logic               PCLoad;
  logic [PC_W-1:0]    JumpTarget;
  logic               Halt;
  logic [INSTR_W-1:0] instruction;
  logic               instr_valid;
  logic [PC_W-1:0]    pc;
  logic               halted;

  modport master (
    output prog_we, prog_addr, prog_data, run, LoadIR, PCLoad, JumpTarget, Halt,
    input  instruction, instr_valid, pc, halted
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, run, LoadIR, PCLoad, JumpTarget, Halt,
    output instruction, instr_valid, pc, halted
  );

endinterface

// File: rtl/instruction_fetch_program_rom.sv
// Small synchronous memory: one write port, one read port with a registered,
// enable-gated output that holds its value between reads.
module program_rom #(
  parameter int                ADDR_W    = 4,
  parameter int                DATA_W    = 8,
  parameter int                DEPTH     = 16,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage is deliberately left out of reset so a loaded program survives it.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= RESET_VAL;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, program memory and a one-entry presented-instruction buffer
// feeding the instruction register.
module instruction_fetch
  import instruction_fetch_pkg::*;
(
  input logic               clk,
  input logic               reset,
  instruction_fetch_if.slave bus
);

  fetch_state_e       state_q;
  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    pc_d;
  logic               instr_valid_q;
  logic               halted_q;
  logic               rom_we;
  logic               rom_re;
  logic [INSTR_W-1:0] rom_rdata;

  // A jump always beats the sequential increment; the add wraps modulo DEPTH.
  assign pc_d = bus.PCLoad ? bus.JumpTarget : pc_q + PC_W'(1);

  assign rom_we = bus.prog_we && (state_q == IDLE);
  // A flushed or halted fetch must not disturb the word last presented.
  assign rom_re = (state_q == FETCH) && !bus.Halt && !bus.PCLoad;

  program_rom #(
    .ADDR_W   (PC_W),
    .DATA_W   (INSTR_W),
    .DEPTH    (DEPTH),
    .RESET_VAL(NOP)
  ) u_rom (
    .clk    (clk),
    .reset  (reset),
    .we_i   (rom_we),
    .waddr_i(bus.prog_addr),
    .wdata_i(bus.prog_data),
    .re_i   (rom_re),
    .raddr_i(pc_q),
    .rdata_o(rom_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          instr_valid_q <= 1'b0;
          if (bus.PCLoad) begin
            pc_q <= bus.JumpTarget;
          end
          if (bus.run) begin
            state_q <= FETCH;
          end
        end
        FETCH: begin
          if (bus.Halt) begin
            state_q       <= HALT;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b1;
          end else if (bus.PCLoad) begin
            pc_q          <= pc_d;
            instr_valid_q <= 1'b0;
          end else begin
            state_q       <= VALID;
            instr_valid_q <= 1'b1;
          end
        end
        VALID: begin
          if (bus.Halt) begin
            state_q       <= HALT;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b1;
          end else if (bus.PCLoad || bus.LoadIR) begin
            state_q       <= FETCH;
            pc_q          <= pc_d;
            instr_valid_q <= 1'b0;
          end
        end
        HALT: begin
          instr_valid_q <= 1'b0;
          halted_q      <= 1'b1;
        end
        default: begin
          state_q       <= IDLE;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.instruction = rom_rdata;
  assign bus.instr_valid = instr_valid_q;
  assign bus.pc          = pc_q;
  assign bus.halted      = halted_q;

endmodule
